// File: rtl/dmem_responder.sv
// Data-memory responder: single-port RAM with 1-cycle registered reads, plus a
// write-count register and a free-running cycle counter at the top two addresses.
module dmem_responder #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address_dmem,
  input  logic [DATA_W-1:0] data,
  input  logic              wren,
  output logic [DATA_W-1:0] q_dmem,
  output logic [15:0]       write_count,
  output logic [ADDR_W-1:0] last_wr_addr
);

  localparam int unsigned RamDepth = (2 ** ADDR_W) - 2;
  localparam logic [ADDR_W-1:0] AddrCycle = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] AddrWcnt  = {{(ADDR_W-1){1'b1}}, 1'b0};

  logic [DATA_W-1:0] mem [0:RamDepth-1];

  logic              is_ram;
  logic              ram_we;
  logic              wcnt_clr;
  logic [DATA_W-1:0] rd_data;
  logic [15:0]       wcnt_d;
  logic [ADDR_W-1:0] last_d;
  logic [31:0]       cycle_q;
  logic [31:0]       cycle_d;

  assign is_ram   = (address_dmem < AddrWcnt);
  assign ram_we   = wren & is_ram & ~reset;
  assign wcnt_clr = wren & (address_dmem == AddrWcnt);

  // RAM is deliberately left out of reset so contents survive it.
  always_ff @(posedge clock) begin
    if (ram_we) begin
      mem[address_dmem] <= data;
    end
  end

  // Read value reflects state before this edge's updates (old-data on RAW).
  always_comb begin
    rd_data = '0;
    if (address_dmem == AddrCycle) begin
      rd_data = DATA_W'(cycle_q);
    end else if (address_dmem == AddrWcnt) begin
      rd_data = DATA_W'(write_count);
    end else if (is_ram) begin
      rd_data = mem[address_dmem];
    end
  end

  always_comb begin
    wcnt_d  = write_count;
    last_d  = last_wr_addr;
    cycle_d = cycle_q + 32'd1;
    if (ram_we) begin
      last_d = address_dmem;
      if (write_count != 16'hFFFF) begin
        wcnt_d = write_count + 16'd1;
      end
    end else if (wcnt_clr) begin
      wcnt_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      q_dmem       <= '0;
      write_count  <= '0;
      last_wr_addr <= '0;
      cycle_q      <= '0;
    end else begin
      q_dmem       <= rd_data;
      write_count  <= wcnt_d;
      last_wr_addr <= last_d;
      cycle_q      <= cycle_d;
    end
  end

endmodule
